// File: rtl/dmem_pkg.sv
// dmem_responder shared types and limits.
// Optional checker: DMEM_PROTO_CHECK_EN.
package dmem_pkg;
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  localparam int WIDX_W  = 15;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 3;
endpackage

// File: rtl/dmem_rd_pipe.sv
// Read-return shift pipe: DEPTH stages of valid+data.
// Synchronous clear drops everything in flight.
module dmem_rd_pipe #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [W-1:0]     d [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++)
        d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: rtl/dmem_responder.sv
// Main-memory responder for the dcache miss port.
// Build option DMEM_PROTO_CHECK_EN enables the sticky proto_err checker.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = WIDX_W,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_din,
  output logic [15:0] mem_dout,
  output logic        rdata_valid,
  output logic        wdone,
  output logic        busy,
  output logic        proto_err
);
  if (RD_LAT < LAT_MIN || RD_LAT > LAT_MAX ||
      WR_LAT < LAT_MIN || WR_LAT > LAT_MAX) begin : g_bad_lat
    $error("dmem_responder: latency out of range");
  end

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  state_t            state, state_n;
  logic [CNT_W-1:0]  wcnt, wcnt_n;
  logic              acc_rd, acc_wr;
  logic [DATA_W-1:0] rd_word;
  logic              unused_addr;

  assign idx         = mem_addr[ADDR_W:1];
  assign unused_addr = ^mem_addr;

  // Write wins when both requests arrive together.
  assign acc_wr = !rst && state == S_IDLE && mem_we;
  assign acc_rd = !rst && state == S_IDLE && mem_re && !mem_we;

  assign rd_word = acc_rd ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (acc_wr)
      mem[idx] <= mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    wdone   = 1'b0;
    busy    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (acc_wr) begin
          state_n = S_WRITE;
          wcnt_n  = CNT_W'(WR_LAT - 1);
        end
      end
      S_WRITE: begin
        if (wcnt == '0) begin
          wdone   = 1'b1;
          state_n = S_IDLE;
        end else begin
          busy   = 1'b1;
          wcnt_n = wcnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  dmem_rd_pipe #(
    .DEPTH (RD_LAT),
    .W     (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (acc_rd),
    .in_data   (rd_word),
    .out_valid (rdata_valid),
    .out_data  (mem_dout)
  );

`ifdef DMEM_PROTO_CHECK_EN
  logic perr;
  logic viol;

  assign viol = (state == S_IDLE && mem_re && mem_we) ||
                (busy && (mem_re || mem_we)) ||
                ((acc_rd || acc_wr) && mem_addr[0]);

  always_ff @(posedge clk) begin
    if (rst)
      perr <= 1'b0;
    else if (viol)
      perr <= 1'b1;
  end

  assign proto_err = perr;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a
// cycle-scheduled reference model.
module tb_dmem_responder;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;
`ifdef DMEM_PROTO_CHECK_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr, mem_din;
  logic [15:0] mem_dout;
  logic        rdata_valid, wdone, busy, proto_err;

  dmem_responder #(
    .ADDR_W (15),
    .RD_LAT (RD_LAT),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .rdata_valid (rdata_valid),
    .wdone       (wdone),
    .busy        (busy),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: word store plus per-cycle scheduled events.
  logic [15:0] mm [int];
  bit          ev_v [int];
  logic [15:0] ev_d [int];
  int          cyc    = 0;
  int          wr_end = -1;
  bit          perr_m = 1'b0;
  logic [15:0] obs [$];
  logic [19:0] last_outs;

  task automatic step(input logic re, input logic we, input logic rs,
                      input logic [15:0] a, input logic [15:0] d);
    bit idle_m, busy_m, ev, viol;
    int wi;
    @(posedge clk);
    #1;
    cyc++;
    ev     = ev_v.exists(cyc);
    busy_m = (cyc < wr_end) && (cyc > wr_end - WR_LAT);
    chk("rvalid", {31'd0, rdata_valid}, {31'd0, ev});
    chk("dout", {16'd0, mem_dout}, {16'd0, ev ? ev_d[cyc] : 16'h0});
    chk("wdone", {31'd0, wdone}, {31'd0, cyc == wr_end});
    chk("busy", {31'd0, busy}, {31'd0, busy_m});
    chk("perr", {31'd0, proto_err}, {31'd0, PE & perr_m});
    last_outs = {rdata_valid, mem_dout, wdone, busy, proto_err};
    if (rdata_valid) obs.push_back(mem_dout);
    rst = rs; mem_re = re; mem_we = we; mem_addr = a; mem_din = d;
    idle_m = cyc > wr_end;
    wi = int'(a[15:1]);
    if (rs) begin
      ev_v.delete();
      ev_d.delete();
      wr_end = -1;
      perr_m = 1'b0;
    end else begin
      viol = (idle_m && re && we) || (busy_m && (re || we)) ||
             (idle_m && (re || we) && a[0]);
      if (viol) perr_m = 1'b1;
      if (idle_m && we) begin
        mm[wi] = d;
        wr_end = cyc + WR_LAT;
      end else if (idle_m && re) begin
        ev_v[cyc + RD_LAT] = 1'b1;
        ev_d[cyc + RD_LAT] = mm[wi];
      end
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    step(0, 1, 0, a, d);
    nop(WR_LAT);
  endtask

  task automatic rd(input logic [15:0] a);
    step(1, 0, 0, a, 16'h0);
    nop(RD_LAT);
  endtask

  logic [15:0] ra;

  initial begin
    rst = 1'b1; mem_re = 0; mem_we = 0; mem_addr = 0; mem_din = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", {16'd0, mem_dout}, 32'd0);
    chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_wdone", {31'd0, wdone}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 48; i++) wr(16'(2 * i), 16'($urandom));
    wr(16'hFFFE, 16'hC0DE);
    for (int i = 0; i < 8; i++) wr(16'h0040 + 16'(2 * i), 16'h1000 + 16'(i));

    // single write then read back
    wr(16'h0010, 16'hBEEF);
    obs.delete();
    rd(16'h0010);
    chk("rd_beef_n", obs.size(), 1);
    chk("rd_beef", {16'd0, obs[$]}, 32'h0000BEEF);

    // 8-word burst refill
    obs.delete();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 16'h0040 + 16'(2 * i), 16'h0);
    nop(RD_LAT + 1);
    chk("burst_n", obs.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst%0d", i), {16'd0, obs[i]}, 32'h1000 + i);

    // write while reads drain, then a read while busy
    step(1, 0, 0, 16'h0020, 16'h0);
    step(1, 0, 0, 16'h0022, 16'h0);
    step(0, 1, 0, 16'h0020, 16'h5555);
    step(1, 0, 0, 16'h0024, 16'h0);
    nop(WR_LAT + RD_LAT);
    obs.delete();
    rd(16'h0020);
    chk("raw_new", {16'd0, obs[$]}, 32'h00005555);

    // simultaneous re+we
    step(1, 1, 0, 16'h0030, 16'h00AA);
    nop(WR_LAT + RD_LAT);
    chk("both_perr", {31'd0, proto_err}, {31'd0, PE});
    obs.delete();
    rd(16'h0030);
    chk("both_data", {16'd0, obs[$]}, 32'h000000AA);

    // reset two cycles after a read
    step(1, 0, 0, 16'h0010, 16'h0);
    nop(1);
    step(0, 0, 1, 16'h0, 16'h0);
    nop(1);
    chk("post_rst_rd", {12'd0, last_outs}, 32'd0);
    nop(RD_LAT + 2);

    // reset during a write
    step(0, 1, 0, 16'h0012, 16'h1234);
    nop(1);
    step(0, 0, 1, 16'h0, 16'h0);
    nop(1);
    chk("post_rst_wr", {12'd0, last_outs}, 32'd0);
    nop(WR_LAT + 1);
    obs.delete();
    rd(16'h0012);
    chk("rst_wr_kept", {16'd0, obs[$]}, 32'h00001234);

    // odd byte address at the top word
    obs.delete();
    rd(16'hFFFF);
    chk("wrap", {16'd0, obs[$]}, 32'h0000C0DE);
    nop(1);
    chk("odd_perr", {31'd0, proto_err}, {31'd0, PE});

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 19))
        0:       ra = 16'hFFFE;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom_range(0, 95));
      endcase
      step(($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 199) == 0), ra, 16'($urandom));
    end
    nop(WR_LAT + RD_LAT + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
